// File: rtl/ccip_reg_pipe_if.sv
// ccip_reg_pipe_if: one valid-tagged CCI-P channel as seen by the register pipe.
// master = upstream/downstream environment, slave = the pipe itself.
// Signal names follow the CCI-P shim so instances drop in without renaming.
interface ccip_reg_pipe_if #(
  parameter int DATA_W     = 552,
  parameter int FIFO_DEPTH = 16
);
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_almostFull;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_almostFull;
  logic [OCC_W-1:0]  occupancy;
  logic              overflow_err;

  modport master (
    output in_valid, in_data, out_almostFull,
    input  in_almostFull, out_valid, out_data, occupancy, overflow_err
  );

  modport slave (
    input  in_valid, in_data, out_almostFull,
    output in_almostFull, out_valid, out_data, occupancy, overflow_err
  );
endinterface

// File: rtl/ccip_reg_pipe.sv
// ccip_reg_pipe: STAGES register stages on one CCI-P channel feeding an elastic FIFO.
// Latency: STAGES+1 cycles from in_valid to out_valid into an empty, unblocked FIFO.
// Backpressure: registered in_almostFull once FIFO plus in-flight stages reach the UP_LAT margin.
module ccip_reg_pipe #(
  parameter int DATA_W     = 552,
  parameter int STAGES     = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int UP_LAT     = 8
) (
  input  logic           pClk,
  input  logic           pck_cp2af_softReset,
  ccip_reg_pipe_if.slave bus
);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = AW + 1;
  localparam int IW     = 3;
  localparam int CW     = OCC_W + 1;
  localparam int AF_THR = FIFO_DEPTH - UP_LAT - 1;

  // Reject configurations where the margin cannot cover upstream reaction time.
  generate
    if (AF_THR < 1) begin : g_bad_margin
      $error("ccip_reg_pipe: FIFO_DEPTH - UP_LAT - 1 must be at least 1");
    end
    if (STAGES < 0 || STAGES > 4) begin : g_bad_stages
      $error("ccip_reg_pipe: STAGES must be within 0..4");
    end
    if (FIFO_DEPTH < 4 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("ccip_reg_pipe: FIFO_DEPTH must be a power of 2 within 4..64");
    end
  endgenerate

  logic              w_wr_vld;
  logic [DATA_W-1:0] w_wr_dat;
  logic [IW-1:0]     w_infl;

  generate
    if (STAGES == 0) begin : g_no_stage
      assign w_wr_vld = bus.in_valid;
      assign w_wr_dat = bus.in_data;
      assign w_infl   = '0;
    end else begin : g_stage
      logic [STAGES-1:0] r_stg_vld;
      logic [DATA_W-1:0] r_stg_dat [STAGES];

      // Valid chain; reset empties it so nothing in flight survives a soft reset.
      always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
        if (pck_cp2af_softReset) begin
          r_stg_vld <= '0;
        end else begin
          r_stg_vld[0] <= bus.in_valid;
          for (int i = 1; i < STAGES; i++) r_stg_vld[i] <= r_stg_vld[i-1];
        end
      end

      // Data chain, free-running and qualified only by the valid chain.
      always_ff @(posedge pClk) begin
        r_stg_dat[0] <= bus.in_data;
        for (int i = 1; i < STAGES; i++) r_stg_dat[i] <= r_stg_dat[i-1];
      end

      // Number of occupied stages: words already committed to land in the FIFO.
      always_comb begin
        w_infl = '0;
        for (int i = 0; i < STAGES; i++) w_infl = w_infl + IW'(r_stg_vld[i]);
      end

      assign w_wr_vld = r_stg_vld[STAGES-1];
      assign w_wr_dat = r_stg_dat[STAGES-1];
    end
  endgenerate

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [OCC_W-1:0]  r_occ;
  logic [OCC_W-1:0]  w_occ_nxt;
  logic              r_out_vld;
  logic [DATA_W-1:0] r_out_dat;
  logic              r_afull;
  logic              r_ovf;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [CW-1:0]     w_cnt;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_full = (r_occ == OCC_W'(FIFO_DEPTH));
  assign w_pop  = (r_occ != '0) && !bus.out_almostFull;
  assign w_push = w_wr_vld && (!w_full || w_pop);
  assign w_drop = w_wr_vld && w_full && !w_pop;
  assign w_cnt  = CW'(r_occ) + CW'(w_infl);

  // Occupancy moves by at most one; simultaneous push and pop cancel.
  always_comb begin
    w_occ_nxt = r_occ;
    if (w_push && !w_pop) begin
      w_occ_nxt = r_occ + OCC_W'(1);
    end else if (!w_push && w_pop) begin
      w_occ_nxt = r_occ - OCC_W'(1);
    end
  end

  // Pointers, occupancy, output valid, backpressure and the sticky drop flag.
  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_occ     <= '0;
      r_out_vld <= 1'b0;
      r_afull   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_occ     <= w_occ_nxt;
      r_out_vld <= w_pop;
      r_afull   <= (w_cnt >= CW'(AF_THR));
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Storage and output data; a write to the head slot while full reads the old word.
  always_ff @(posedge pClk) begin
    if (w_push) r_mem[r_wptr] <= w_wr_dat;
    if (w_pop)  r_out_dat     <= r_mem[r_rptr];
  end

  assign bus.out_valid     = r_out_vld;
  assign bus.out_data      = r_out_dat;
  assign bus.in_almostFull = r_afull;
  assign bus.occupancy     = r_occ;
  assign bus.overflow_err  = r_ovf;
endmodule

// File: tb/tb_ccip_reg_pipe.sv
// tb_ccip_reg_pipe: directed scenarios against a queue-based reference model.
// The model tracks each accepted word from input edge to FIFO to output.
// Directed literal expectations pin latency, margins and boundary cases.
module tb_ccip_reg_pipe;
  localparam int DW  = 552;
  localparam int ST  = 2;
  localparam int FD  = 16;
  localparam int UL  = 8;
  localparam int THR = FD - UL - 1;

  typedef struct {
    int            due;
    logic [DW-1:0] dat;
  } pend_t;

  logic pClk;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  ccip_reg_pipe_if #(.DATA_W(DW), .FIFO_DEPTH(FD)) bif ();

  ccip_reg_pipe #(.DATA_W(DW), .STAGES(ST), .FIFO_DEPTH(FD), .UP_LAT(UL)) dut (
    .pClk               (pClk),
    .pck_cp2af_softReset(rst),
    .bus                (bif.slave)
  );

  initial pClk = 1'b0;
  always #5 pClk = ~pClk;

  // reference model state
  logic [DW-1:0] mq[$];
  pend_t         pend[$];
  int            m_edge  = 0;
  int            m_cprev = 0;
  logic          m_vld   = 1'b0;
  logic          m_ovf   = 1'b0;
  logic          m_afull = 1'b0;
  logic [DW-1:0] m_dat;

  // observed outputs
  logic [DW-1:0] outq[$];
  int            outc[$];

  function automatic logic [DW-1:0] mk(input int i);
    logic [31:0] w;
    w = i;
    return {{17{w ^ 32'h5A5A_0000}}, w[7:0]};
  endfunction

  function automatic int bad_order(input int base);
    int b = 0;
    for (int k = 0; k < outq.size(); k++) if (outq[k] !== mk(base + k)) b++;
    return b;
  endfunction

  task automatic chk(input string nm, input integer act, input integer exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge pClk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [DW-1:0] d, input logic oaf);
    bif.in_valid       = v;
    bif.in_data        = d;
    bif.out_almostFull = oaf;
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b1;
    set_in(1'b0, '0, 1'b0);
    #1;
    chk("rst_out_valid", integer'(bif.out_valid), 0);
    chk("rst_occupancy", integer'(bif.occupancy), 0);
    chk("rst_in_almostFull", integer'(bif.in_almostFull), 0);
    chk("rst_overflow_err", integer'(bif.overflow_err), 0);
    repeat (hold) nxt();
    rst = 1'b0;
  endtask

  // edge counter, zero while reset is held
  initial forever begin
    @(posedge pClk or posedge rst);
    if (rst) cyc = 0;
    else     cyc++;
  end

  // reference model: each input lands in the FIFO STAGES edges after it is sampled
  initial begin : model
    logic  pop;
    int    sz0;
    pend_t pe;
    forever begin
      @(posedge pClk or posedge rst);
      if (rst) begin
        mq.delete();
        pend.delete();
        m_edge  = 0;
        m_cprev = 0;
        m_vld   = 1'b0;
        m_ovf   = 1'b0;
        m_afull = 1'b0;
      end else begin
        m_edge++;
        m_afull = (m_cprev >= THR);
        sz0 = mq.size();
        pop = (sz0 != 0) && !bif.out_almostFull;
        if (pop) m_dat = mq.pop_front();
        m_vld = pop;
        if (bif.in_valid) begin
          pe.due = m_edge + ST;
          pe.dat = bif.in_data;
          pend.push_back(pe);
        end
        if (pend.size() != 0 && pend[0].due == m_edge) begin
          pe = pend.pop_front();
          if (sz0 == FD && !pop) m_ovf = 1'b1;
          else                   mq.push_back(pe.dat);
        end
        m_cprev = mq.size() + pend.size();
      end
    end
  end

  // per-cycle comparison of every output against the model
  initial forever begin
    @(negedge pClk);
    if (!rst) begin
      chk("cmp_out_valid", integer'(bif.out_valid), integer'(m_vld));
      if (m_vld) chkd("cmp_out_data", bif.out_data, m_dat);
      chk("cmp_occupancy", integer'(bif.occupancy), mq.size());
      chk("cmp_in_almostFull", integer'(bif.in_almostFull), integer'(m_afull));
      chk("cmp_overflow_err", integer'(bif.overflow_err), integer'(m_ovf));
    end
  end

  // output recorder
  initial forever begin
    @(negedge pClk);
    if (!rst && bif.out_valid === 1'b1) begin
      outq.push_back(bif.out_data);
      outc.push_back(cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int occ12, peak, tin, n, n_at, seen_af;
    do_reset(3);

    // single word 0xA5 sampled at cycle 10
    outq.delete(); outc.delete();
    repeat (9) nxt();
    set_in(1'b1, DW'(8'hA5), 1'b0);
    nxt();
    set_in(1'b0, '0, 1'b0);
    occ12 = -1; peak = 0;
    repeat (8) begin
      nxt();
      if (cyc == 12) occ12 = integer'(bif.occupancy);
      if (integer'(bif.occupancy) > peak) peak = integer'(bif.occupancy);
    end
    chk("t1_out_count", outq.size(), 1);
    chk("t1_out_cycle", (outc.size() != 0) ? outc[0] : -1, 13);
    chkd("t1_out_data", (outq.size() != 0) ? outq[0] : '0, DW'(8'hA5));
    chk("t1_occ_cycle12", occ12, 1);
    chk("t1_occ_peak", peak, 1);

    // 100 back-to-back words, downstream open
    outq.delete(); outc.delete();
    tin = cyc + 1; seen_af = 0;
    for (int i = 0; i < 100; i++) begin
      set_in(1'b1, mk(i), 1'b0);
      nxt();
      if (bif.in_almostFull === 1'b1) seen_af = 1;
    end
    set_in(1'b0, '0, 1'b0);
    repeat (10) begin
      nxt();
      if (bif.in_almostFull === 1'b1) seen_af = 1;
    end
    chk("t2_out_count", outq.size(), 100);
    chk("t2_first_latency", (outc.size() != 0) ? outc[0] - tin : -1, 3);
    chk("t2_back_to_back", (outc.size() == 100) ? outc[99] - outc[0] : -1, 99);
    chk("t2_order_errors", bad_order(0), 0);
    chk("t2_almostFull_seen", seen_af, 0);
    chk("t2_overflow_err", integer'(bif.overflow_err), 0);

    // downstream blocked, upstream honours almost-full with an 8-cycle tail
    outq.delete(); outc.delete();
    n = 0; n_at = 0;
    for (int k = 0; k < 40; k++) begin
      if (n_at != 0 && n == n_at + UL) break;
      set_in(1'b1, mk(100 + n), 1'b1);
      n++;
      nxt();
      if (n_at == 0 && bif.in_almostFull === 1'b1) n_at = n;
    end
    set_in(1'b0, '0, 1'b1);
    repeat (4) nxt();
    chk("t3_words_at_almostFull", n_at, 8);
    chk("t3_words_sent", n, 16);
    chk("t3_occupancy", integer'(bif.occupancy), 16);
    chk("t3_overflow_err", integer'(bif.overflow_err), 0);
    chk("t3_no_out_while_blocked", outq.size(), 0);
    set_in(1'b0, '0, 1'b0);
    repeat (25) nxt();
    chk("t3_drain_count", outq.size(), 16);
    chk("t3_drain_order_errors", bad_order(100), 0);

    // upstream ignores almost-full: 20 words into 16 slots
    outq.delete(); outc.delete();
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, mk(200 + i), 1'b1);
      nxt();
    end
    set_in(1'b0, '0, 1'b1);
    repeat (4) nxt();
    chk("t4_occupancy", integer'(bif.occupancy), 16);
    chk("t4_overflow_err", integer'(bif.overflow_err), 1);
    set_in(1'b0, '0, 1'b0);
    repeat (25) nxt();
    chk("t4_drain_count", outq.size(), 16);
    chk("t4_drain_order_errors", bad_order(200), 0);
    chk("t4_overflow_sticky", integer'(bif.overflow_err), 1);
    chk("t4_occ_empty", integer'(bif.occupancy), 0);

    nxt();
    do_reset(2);

    // full FIFO: write lands on the same edge as the first pop
    outq.delete(); outc.delete();
    for (int i = 0; i < 16; i++) begin
      set_in(1'b1, mk(300 + i), 1'b1);
      nxt();
    end
    set_in(1'b0, '0, 1'b1);
    repeat (4) nxt();
    chk("t5_full_before", integer'(bif.occupancy), 16);
    set_in(1'b1, mk(316), 1'b1);
    nxt();
    set_in(1'b0, '0, 1'b1);
    nxt();
    set_in(1'b0, '0, 1'b0);
    nxt();
    chk("t5_occ_write_pop", integer'(bif.occupancy), 16);
    chk("t5_overflow_err", integer'(bif.overflow_err), 0);
    chk("t5_first_pop", outq.size(), 1);
    repeat (25) nxt();
    chk("t5_drain_count", outq.size(), 17);
    chk("t5_drain_order_errors", bad_order(300), 0);
    chkd("t5_last_word", (outq.size() != 0) ? outq[outq.size() - 1] : '0, mk(316));
    chk("t5_overflow_after", integer'(bif.overflow_err), 0);

    // reset with 5 buffered, 2 in flight and an output pulse in progress
    nxt();
    do_reset(1);
    for (int i = 0; i < 7; i++) begin
      set_in(1'b1, mk(400 + i), 1'b1);
      nxt();
    end
    set_in(1'b0, '0, 1'b1);
    repeat (3) nxt();
    chk("t6_preload_occ", integer'(bif.occupancy), 7);
    chk("t6_preload_afull", integer'(bif.in_almostFull), 1);
    set_in(1'b1, mk(407), 1'b0);
    nxt();
    set_in(1'b1, mk(408), 1'b0);
    nxt();
    chk("t6_pre_occ", integer'(bif.occupancy), 5);
    chk("t6_pre_out_valid", integer'(bif.out_valid), 1);
    chk("t6_pre_afull", integer'(bif.in_almostFull), 1);
    do_reset(1);
    outq.delete(); outc.delete();
    repeat (8) nxt();
    chk("t6_no_stale_output", outq.size(), 0);
    tin = cyc + 1;
    set_in(1'b1, mk(500), 1'b0);
    nxt();
    set_in(1'b0, '0, 1'b0);
    repeat (8) nxt();
    chk("t6_post_count", outq.size(), 1);
    chk("t6_post_latency", (outc.size() != 0) ? outc[0] - tin : -1, 3);
    chkd("t6_post_data", (outq.size() != 0) ? outq[0] : '0, mk(500));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ccip_reg_pipe.md
Name: ccip_reg_pipe

Overview:
- Parametrised successor to the fixed single-stage CCI-P register slice.
- Inserts STAGES register stages on one valid-tagged CCI-P channel, then an elastic FIFO that absorbs in-flight traffic.
- Relays almost-full backpressure upstream with a computed margin, so the extra stages never cause data loss.
- One instance is placed per Tx/Rx channel between the green-region AFU and the CCI-P shim, for timing closure across long routes.

Parameters:
- DATA_W, 552, payload width (packed channel header plus data).
- STAGES, 2, number of register stages before the FIFO; legal range 0..4.
- FIFO_DEPTH, 16, elastic FIFO entries; power of 2, range 4..64.
- UP_LAT, 8, maximum cycles upstream may continue asserting in_valid after seeing in_almostFull.
- Elaboration error if FIFO_DEPTH - UP_LAT - 1 < 1.

Ports:
- pClk  in  1  CCI-P interface clock; all logic on its rising edge.
- pck_cp2af_softReset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream transfer valid.
- in_data  in  DATA_W  upstream payload.
- in_almostFull  out  1  backpressure to upstream.
- out_valid  out  1  downstream transfer valid.
- out_data  out  DATA_W  downstream payload.
- out_almostFull  in  1  backpressure from downstream.
- occupancy  out  $clog2(FIFO_DEPTH)+1  current FIFO entry count.
- overflow_err  out  1  sticky: a write was dropped.

Behaviour:
- Reset: clock is pClk; reset is asynchronous and active-high. While reset is asserted:
  - all stage valids = 0;
  - FIFO read/write pointers = 0, occupancy = 0;
  - out_valid = 0, in_almostFull = 0, overflow_err = 0.
- Data registers are not reset. out_data is don't-care while out_valid = 0.
- Pipeline:
  - Stage k captures the valid/data of stage k-1 every cycle; there is no stall.
  - Stage 0 captures in_valid/in_data.
  - When STAGES = 0, in_valid/in_data drive the FIFO write port directly.
- FIFO write: last-stage valid = 1 → entry written at that edge.
- FIFO pop:
  - pop = (occupancy != 0) && !out_almostFull, evaluated in the current cycle.
  - On pop, the head is registered into out_data and out_valid = 1 next cycle.
  - Otherwise out_valid = 0 next cycle. out_valid is a single-cycle pulse per entry.
- Latency: empty FIFO, out_almostFull = 0, in_valid at cycle t → out_valid at cycle t + STAGES + 1. Back-to-back input gives back-to-back output.
- Order: strict FIFO; no reordering, duplication or loss below the overflow condition.
- Almost-full:
  - Define C = occupancy + number of valid pipeline stages.
  - Register in_almostFull <= (C >= FIFO_DEPTH - UP_LAT - 1); asserted/deasserted one cycle after the condition changes.
  - This threshold guarantees no overflow when upstream obeys UP_LAT.
- out_almostFull is not piped upstream; it only gates pop.
- Boundary conditions:
  - Write while full, with no pop that cycle: entry dropped, occupancy stays FIFO_DEPTH, overflow_err <= 1 (sticky until reset).
  - Write and pop in the same cycle while full: legal; occupancy unchanged; no error.
  - Write and pop in the same cycle with occupancy = 1: legal; the popped entry is the old head.
  - Pop never occurs when empty; a write to an empty FIFO is poppable the following cycle, with no same-cycle bypass.
  - Pointers wrap modulo FIFO_DEPTH; occupancy saturates at FIFO_DEPTH and never goes below 0.
- Reset mid-operation: in-flight and buffered entries are discarded with no partial output. The first post-reset input follows the normal latency.
- occupancy is registered and reflects the FIFO state after the previous edge.

Test Plan:
- STAGES=2, FIFO_DEPTH=16: single in_valid, data 0xA5, at cycle 10 → out_valid exactly at cycle 13, out_data = 0xA5; occupancy peaks at 1 in cycle 12.
- 100 consecutive writes of an incrementing pattern, out_almostFull = 0 → 100 consecutive outputs in order starting 3 cycles later; in_almostFull never asserts; overflow_err = 0.
- Hold out_almostFull = 1 and stream writes, with upstream stopping exactly 8 cycles after in_almostFull:
  - in_almostFull rises the cycle after C reaches 7;
  - occupancy ends ≤ 16; overflow_err = 0;
  - releasing out_almostFull drains all entries in order.
- Same as previous, but upstream ignores in_almostFull and sends 20 words → occupancy saturates at 16, overflow_err = 1 and stays 1; the first 16 words drain in order.
- FIFO full with out_almostFull dropping the same cycle a write arrives → occupancy stays 16, no error, the new word emerges last.
- Assert reset for 1 cycle with 5 entries buffered and 2 in-flight → out_valid, occupancy and in_almostFull all 0 immediately; no stale output afterwards; the next write appears STAGES+1 cycles later.
